// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch-request unit: owns the architectural PC, picks the
// next PC from sequential/relative/indirect/trap-return sources, and handshakes with imem.
module pc_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = '0,
    parameter int               CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              sel,
    input  logic signed [XLEN-1:0]  imm_pc_off,
    input  logic [XLEN-1:0]         pc_from_reg,
    input  logic                    trap_take,
    input  logic [XLEN-1:0]         trap_vec,
    input  logic                    fetch_ack,
    output logic [XLEN-1:0]         iaddr,
    output logic                    fetch_req,
    output logic                    fault,
    output logic [XLEN-1:0]         fault_addr,
    output logic [XLEN-1:0]         saved_pc,
    output logic [CNT_W-1:0]        fetch_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            advance;

    always_comb begin
        next_pc = iaddr + XLEN'(4);
        case (sel)
            2'b00: next_pc = iaddr + XLEN'(4);
            2'b01: next_pc = $unsigned($signed(iaddr) + imm_pc_off);
            2'b10: next_pc = {pc_from_reg[XLEN-1:1], 1'b0};
            2'b11: next_pc = saved_pc;
            default: next_pc = iaddr + XLEN'(4);
        endcase
    end

    assign next_misaligned = |next_pc[1:0];
    assign advance         = fetch_ack && !stall;

    // fetch_req is a pure state decode, so no input reaches it combinationally
    assign fetch_req = (state == ST_REQ);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            iaddr       <= RESET_VEC;
            fault       <= 1'b0;
            fault_addr  <= '0;
            saved_pc    <= '0;
            fetch_count <= '0;
        end else if (trap_take) begin
            iaddr      <= {trap_vec[XLEN-1:2], 2'b00};
            saved_pc   <= iaddr;
            fault      <= 1'b0;
            fault_addr <= '0;
            state      <= ST_REQ;
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (advance) begin
                        if (next_misaligned) begin
                            state      <= ST_FAULT;
                            fault      <= 1'b1;
                            fault_addr <= next_pc;
                        end else begin
                            iaddr       <= next_pc;
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                    end
                end
                // Only trap_take or reset leave FAULT; both are handled above
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit with RESET_VEC=0x100 and a 4-bit fetch counter.
module tb_pc_fetch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   reset;
    logic                   stall;
    logic [1:0]             sel;
    logic signed [XLEN-1:0] imm_pc_off;
    logic [XLEN-1:0]        pc_from_reg;
    logic                   trap_take;
    logic [XLEN-1:0]        trap_vec;
    logic                   fetch_ack;
    logic [XLEN-1:0]        iaddr;
    logic                   fetch_req;
    logic                   fault;
    logic [XLEN-1:0]        fault_addr;
    logic [XLEN-1:0]        saved_pc;
    logic [CNT_W-1:0]       fetch_count;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (32'h0000_0100),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .sel         (sel),
        .imm_pc_off  (imm_pc_off),
        .pc_from_reg (pc_from_reg),
        .trap_take   (trap_take),
        .trap_vec    (trap_vec),
        .fetch_ack   (fetch_ack),
        .iaddr       (iaddr),
        .fetch_req   (fetch_req),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .saved_pc    (saved_pc),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_iaddr"}, 64'(iaddr), 64'h100);
        check({tag, "_req"},   64'(fetch_req), 64'd0);
        check({tag, "_fault"}, 64'(fault), 64'd0);
        check({tag, "_faddr"}, 64'(fault_addr), 64'd0);
        check({tag, "_saved"}, 64'(saved_pc), 64'd0);
        check({tag, "_cnt"},   64'(fetch_count), 64'd0);
    endtask

    task automatic trap_to(input logic [XLEN-1:0] vec);
        trap_take = 1'b1;
        trap_vec  = vec;
        tick();
        trap_take = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; sel = 2'b00; imm_pc_off = '0;
        pc_from_reg = '0; trap_take = 1'b0; trap_vec = '0; fetch_ack = 1'b1;
        #2;

        // Reset and sequential fetch
        tick(); tick();
        check_reset_state("rst");
        reset = 1'b1;
        tick();
        check("idle_exit_req", 64'(fetch_req), 64'd1);
        check("idle_exit_pc",  64'(iaddr), 64'h100);
        tick();
        check("seq1_pc", 64'(iaddr), 64'h104);
        tick();
        check("seq2_pc",  64'(iaddr), 64'h108);
        check("seq2_cnt", 64'(fetch_count), 64'd2);
        fetch_ack = 1'b0;

        // Branch and jalr
        trap_to(32'h200);
        check("trap200_pc",    64'(iaddr), 64'h200);
        check("trap200_saved", 64'(saved_pc), 64'h108);
        check("trap200_cnt",   64'(fetch_count), 64'd2);
        fetch_ack = 1'b1; sel = 2'b01; imm_pc_off = -32'sd8;
        tick();
        check("br_neg_pc",  64'(iaddr), 64'h1F8);
        check("br_neg_cnt", 64'(fetch_count), 64'd3);
        sel = 2'b10; pc_from_reg = 32'h301;
        tick();
        check("jalr_pc",  64'(iaddr), 64'h300);
        check("jalr_cnt", 64'(fetch_count), 64'd4);

        // Stall and ack gating
        sel = 2'b00; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",  64'(iaddr), 64'h300);
            check("stall_req", 64'(fetch_req), 64'd1);
            check("stall_cnt", 64'(fetch_count), 64'd4);
        end
        fetch_ack = 1'b0; stall = 1'b0;
        tick();
        check("noack_pc", 64'(iaddr), 64'h300);
        fetch_ack = 1'b1;
        tick();
        check("release_pc",  64'(iaddr), 64'h304);
        check("release_cnt", 64'(fetch_count), 64'd5);
        fetch_ack = 1'b0;

        // Misaligned target
        trap_to(32'h400);
        check("trap400_pc", 64'(iaddr), 64'h400);
        fetch_ack = 1'b1; sel = 2'b01; imm_pc_off = 32'sd6;
        tick();
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_faddr", 64'(fault_addr), 64'h406);
        check("mis_pc",    64'(iaddr), 64'h400);
        check("mis_req",   64'(fetch_req), 64'd0);
        check("mis_cnt",   64'(fetch_count), 64'd5);
        sel = 2'b00;
        tick(); tick();
        check("flt_hold_pc",    64'(iaddr), 64'h400);
        check("flt_hold_fault", 64'(fault), 64'd1);
        check("flt_hold_cnt",   64'(fetch_count), 64'd5);

        // Trap out of FAULT while stalled, then return via saved_pc
        stall = 1'b1;
        trap_to(32'h803);
        check("trap803_pc",    64'(iaddr), 64'h800);
        check("trap803_saved", 64'(saved_pc), 64'h400);
        check("trap803_fault", 64'(fault), 64'd0);
        check("trap803_faddr", 64'(fault_addr), 64'd0);
        check("trap803_req",   64'(fetch_req), 64'd1);
        stall = 1'b0; sel = 2'b11;
        tick();
        check("ret_pc",  64'(iaddr), 64'h400);
        check("ret_cnt", 64'(fetch_count), 64'd6);

        // 17th accepted fetch since reset wraps the 4-bit counter to 1
        sel = 2'b00;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (i == 9) check("cnt_wrap0", 64'(fetch_count), 64'd0);
        end
        check("cnt_wrap1", 64'(fetch_count), 64'd1);
        check("cnt_pc",    64'(iaddr), 64'h42C);

        // PC wraps modulo 2^XLEN
        fetch_ack = 1'b0;
        trap_to(32'hFFFF_FFFC);
        fetch_ack = 1'b1;
        tick();
        check("pc_wrap",     64'(iaddr), 64'h0);
        check("pc_wrap_cnt", 64'(fetch_count), 64'd2);

        // Reset during a stall
        stall = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_reset_state("rst_stall");

        // Reset while in FAULT (jalr target with bit 1 set)
        reset = 1'b1; stall = 1'b0; fetch_ack = 1'b0;
        tick();
        trap_to(32'h500);
        fetch_ack = 1'b1; sel = 2'b10; pc_from_reg = 32'h503;
        tick();
        check("jalr_mis_fault", 64'(fault), 64'd1);
        check("jalr_mis_faddr", 64'(fault_addr), 64'h502);
        reset = 1'b0;
        tick();
        check_reset_state("rst_fault");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and fetch-request unit for the single-issue core. It owns the architectural PC register and selects the next PC from sequential, PC-relative, register-indirect (jalr) and return-from-trap sources. It also drives a req/ack handshake to instruction memory, detects misaligned targets, and counts accepted fetches. It sits between the decoder/branch resolution logic and the instruction memory port.

## Interface
Parameters:
- XLEN, 32, PC/data width in bits (≥ 8).
- RESET_VEC, 0, PC value loaded on reset. Must be 4-byte aligned.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- stall  in  1  hold current PC; no advance this cycle.
- sel  in  2  next-PC source: 00 = pc+4, 01 = pc+imm_pc_off, 10 = pc_from_reg with bit 0 cleared, 11 = saved_pc (trap return).
- imm_pc_off  in  XLEN  signed PC-relative offset.
- pc_from_reg  in  XLEN  jalr target (rs1+imm, already summed).
- trap_take  in  1  redirect to trap vector; highest non-reset priority.
- trap_vec  in  XLEN  trap handler address.
- fetch_ack  in  1  instruction memory accepted the current iaddr.
- iaddr  out  XLEN  current PC / fetch address (registered).
- fetch_req  out  1  fetch request valid (decoded from state).
- fault  out  1  misaligned-target fault pending (registered).
- fault_addr  out  XLEN  offending target address.
- saved_pc  out  XLEN  PC captured on trap_take.
- fetch_count  out  CNT_W  number of accepted, advanced fetches.

## Operation
- States: IDLE, REQ, FAULT.
- Reset (reset==0 at edge): iaddr=RESET_VEC, state=IDLE, fetch_req=0, fault=0, fault_addr=0, saved_pc=0, fetch_count=0.
- IDLE: fetch_req=0. The state moves to REQ on the next edge unconditionally.
- REQ: fetch_req=1, and iaddr is held stable until advance. Advance happens when fetch_ack=1 and stall=0 and trap_take=0:
  - next computed per sel. All sums are XLEN-bit modulo 2^XLEN, and overflow wraps silently. imm_pc_off is added as two's complement.
  - if next[1:0]!=0: state=FAULT, fault=1, fault_addr=next, iaddr unchanged, fetch_count unchanged.
  - else: iaddr=next, fetch_count+=1 (wraps at 2^CNT_W), state stays REQ.
- fetch_ack=1 with stall=1: no advance, iaddr held, fetch_req stays 1 (the fetch is re-issued).
- fetch_ack=0: no advance regardless of stall/sel.
- FAULT: fetch_req=0. All inputs are ignored except trap_take and reset.
- trap_take=1 in any state: iaddr = trap_vec with bits [1:0] forced to 0, saved_pc = current iaddr, fault=0, fault_addr=0, state=REQ. fetch_count is unchanged. Ignores stall/ack.
- sel=11 uses the saved_pc value held before the edge.
- Priority per edge: reset > trap_take > stall > advance.

## Timing
- Single-cycle update: a new iaddr is visible the cycle after the accepting edge.
- fetch_req rises in the second cycle after reset is released (one IDLE cycle).
- Back-to-back: with ack=1 and stall=0 every cycle, iaddr advances every cycle.
- fault asserts the cycle after the misaligned advance and holds until trap_take or reset.
- Reset mid-REQ or in FAULT: all outputs take their reset values on that edge, and pending state is discarded.
- No combinational path from inputs to outputs. fetch_req depends on state only.

## Test plan
- Reset/sequential: hold reset=0 for 2 cycles with RESET_VEC=0x100, then release with ack=1, sel=00. Expect iaddr 0x100 in IDLE, fetch_req=1 the next cycle, then iaddr 0x104, 0x108, and fetch_count=2 after two accepts.
- Branch/jalr: at iaddr=0x200, sel=01 with imm=-8 → 0x1F8. Then sel=10 with pc_from_reg=0x301 → 0x300. fetch_count increments on each.
- Stall/ack: ack=1 with stall=1 for 3 cycles → iaddr and fetch_req unchanged and count constant. Then ack=0 with stall=0 → no change. Release both → advance once.
- Misaligned fault: at 0x400, sel=01 with imm=6 → fault=1, fault_addr=0x406, iaddr=0x400, fetch_req=0. Ack and sel are ignored until trap_take.
- Trap and return: in FAULT, trap_take=1 with trap_vec=0x803 → iaddr=0x800, saved_pc=0x400, fault=0. A later advance with sel=11 → iaddr=0x400. trap_take together with stall=1 must still redirect.
- Wrap/reset mid-op: CNT_W=4 with 17 accepts → fetch_count=1. iaddr=0xFFFFFFFC with sel=00 → 0x0. Assert reset during a stall → all outputs take their reset values on that edge.
